sequence_presenter: RTL and testbench

//  Plays the stored game sequence to the player: steps ROM addresses 0..ultimo, fetches

---
 rtl/sequence_presenter.sv | 135 +++++++++++++
 tb/tb_sequence_presenter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sequence_presenter.sv
// Plays ROM entries 0..ultimo on the leds: lit for ON_CYCLES, dark for OFF_CYCLES.
// Optional PAUSE_EN macro adds a pausa input that freezes SHOW/GAP timing.
module sequence_presenter #(
  parameter int unsigned ON_CYCLES  = 1000,
  parameter int unsigned OFF_CYCLES = 500,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned DATA_W     = 4
) (
  input  logic              clock,
  input  logic              clear,
`ifdef PAUSE_EN
  input  logic              pausa,
`endif
  input  logic              iniciar,
  input  logic [ADDR_W-1:0] ultimo,
  input  logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] leds,
  output logic              exibindo,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  localparam int unsigned MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC + 1) : 1;
  localparam int unsigned ON_LAST_I  = (ON_CYCLES > 0) ? ON_CYCLES - 1 : 0;
  localparam int unsigned OFF_LAST_I = (OFF_CYCLES > 0) ? OFF_CYCLES - 1 : 0;
  localparam logic [TIMER_W-1:0] ON_LAST  = TIMER_W'(ON_LAST_I);
  localparam logic [TIMER_W-1:0] OFF_LAST = TIMER_W'(OFF_LAST_I);
  localparam bit HAS_GAP = (OFF_CYCLES > 0);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_WAIT_ROM = 4'd2,
    S_SHOW     = 4'd3,
    S_GAP      = 4'd4,
    S_NEXT     = 4'd5,
    S_DONE     = 4'd6
  } state_t;

  state_t              state, state_nxt;
  logic [TIMER_W-1:0]  timer, timer_nxt;
  logic [ADDR_W-1:0]   ultimo_r, ultimo_nxt;
  logic [ADDR_W-1:0]   endereco_nxt;
  logic [DATA_W-1:0]   leds_nxt;
  logic                hold;

`ifdef PAUSE_EN
  assign hold = pausa;
`else
  assign hold = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= S_IDLE;
      timer    <= '0;
      ultimo_r <= '0;
      endereco <= '0;
      leds     <= '0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      ultimo_r <= ultimo_nxt;
      endereco <= endereco_nxt;
      leds     <= leds_nxt;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    ultimo_nxt   = ultimo_r;
    endereco_nxt = endereco;
    leds_nxt     = leds;
    case (state)
      S_IDLE: begin
        leds_nxt = '0;
        if (iniciar) begin
          endereco_nxt = '0;
          ultimo_nxt   = ultimo;
          state_nxt    = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_WAIT_ROM;
      S_WAIT_ROM: begin
        leds_nxt  = mem_data;
        timer_nxt = '0;
        state_nxt = S_SHOW;
      end
      S_SHOW: begin
        if (!hold) begin
          if (timer == ON_LAST) begin
            timer_nxt = '0;
            leds_nxt  = '0;
            state_nxt = HAS_GAP ? S_GAP : S_NEXT;
          end else begin
            timer_nxt = timer + TIMER_W'(1);
          end
        end
      end
      S_GAP: begin
        leds_nxt = '0;
        if (!hold) begin
          if (timer == OFF_LAST) begin
            timer_nxt = '0;
            state_nxt = S_NEXT;
          end else begin
            timer_nxt = timer + TIMER_W'(1);
          end
        end
      end
      S_NEXT: begin
        // Ending here keeps endereco from ever wrapping past the last entry
        if (endereco == ultimo_r) begin
          state_nxt = S_DONE;
        end else begin
          endereco_nxt = endereco + ADDR_W'(1);
          state_nxt    = S_FETCH;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status decodes straight from the state register
  assign exibindo  = (state != S_IDLE) && (state != S_DONE);
  assign pronto    = (state == S_DONE);
  assign db_estado = state;

endmodule

// File: tb/tb_sequence_presenter.sv
// Scoreboard bench for sequence_presenter: per-cycle expected outputs are queued at
// each start and popped against the DUT on every falling edge.
module tb_sequence_presenter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       clear, iniciar, iniciar0;
  logic [3:0] ultimo;
  logic [3:0] mem_data, mem_data0, endereco, endereco0, leds, leds0, db, db0;
  logic       exib, exib0, pronto, pronto0;
`ifdef PAUSE_EN
  logic       pausa, pausa0;
`endif

  logic [3:0] rom [16];

  sequence_presenter #(.ON_CYCLES(3), .OFF_CYCLES(2), .ADDR_W(4), .DATA_W(4)) dut (
    .clock(clock), .clear(clear),
`ifdef PAUSE_EN
    .pausa(pausa),
`endif
    .iniciar(iniciar), .ultimo(ultimo), .mem_data(mem_data),
    .endereco(endereco), .leds(leds), .exibindo(exib), .pronto(pronto), .db_estado(db)
  );

  sequence_presenter #(.ON_CYCLES(3), .OFF_CYCLES(0), .ADDR_W(4), .DATA_W(4)) dut0 (
    .clock(clock), .clear(clear),
`ifdef PAUSE_EN
    .pausa(pausa0),
`endif
    .iniciar(iniciar0), .ultimo(ultimo), .mem_data(mem_data0),
    .endereco(endereco0), .leds(leds0), .exibindo(exib0), .pronto(pronto0), .db_estado(db0)
  );

  always @(posedge clock) begin
    mem_data  <= rom[endereco];
    mem_data0 <= rom[endereco0];
  end

  typedef struct packed {
    logic [3:0] leds;
    logic       exib;
    logic       pronto;
    logic [3:0] addr;
    logic [3:0] st;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic obs_t mk(input logic [3:0] l, input logic e, input logic p,
                              input int a, input logic [3:0] s);
    obs_t o;
    o.leds = l; o.exib = e; o.pronto = p; o.addr = 4'(a); o.st = s;
    return o;
  endfunction

  function automatic obs_t sample(input bit sel);
    obs_t o;
    if (sel) o = mk(leds0, exib0, pronto0, int'(endereco0), db0);
    else     o = mk(leds, exib, pronto, int'(endereco), db);
    return o;
  endfunction

  // Expected trace of one run, one entry per clock after the start edge
  task automatic push_run(input int ult, input int on, input int off, input int pause_len);
    for (int k = 0; k <= ult; k++) begin
      exp_q.push_back(mk(4'h0, 1'b1, 1'b0, k, 4'd1));
      exp_q.push_back(mk(4'h0, 1'b1, 1'b0, k, 4'd2));
      for (int i = 0; i < on + ((k == 0) ? pause_len : 0); i++)
        exp_q.push_back(mk(rom[k], 1'b1, 1'b0, k, 4'd3));
      for (int i = 0; i < off; i++)
        exp_q.push_back(mk(4'h0, 1'b1, 1'b0, k, 4'd4));
      exp_q.push_back(mk(4'h0, 1'b1, 1'b0, k, 4'd5));
    end
    exp_q.push_back(mk(4'h0, 1'b0, 1'b1, ult, 4'd6));
    exp_q.push_back(mk(4'h0, 1'b0, 1'b0, ult, 4'd0));
  endtask

  task automatic compare(input obs_t a, input obs_t e, input string tag, input int t);
    n_checks++;
    assert (a === e) else begin
      n_fail++;
      $error("FAIL %s t=%0d: observed leds=%h exib=%b pronto=%b addr=%h st=%0d, expected leds=%h exib=%b pronto=%b addr=%h st=%0d",
             tag, t, a.leds, a.exib, a.pronto, a.addr, a.st,
             e.leds, e.exib, e.pronto, e.addr, e.st);
    end
  endtask

  // Start a run on one DUT and check every clock; optional mid-run events
  task automatic run(input bit sel, input int ult, input int on, input int off,
                     input int pause_len, input int pause_at, input int inject_at,
                     input int clear_at, input string tag);
    int t;
    obs_t e;
    push_run(ult, on, off, pause_len);
    @(negedge clock);
    ultimo = 4'(ult);
    if (sel) iniciar0 = 1'b1; else iniciar = 1'b1;
    @(posedge clock);
    #1;
    iniciar = 1'b0; iniciar0 = 1'b0;
    t = 0;
    while (exp_q.size() > 0) begin
      @(negedge clock);
      e = exp_q.pop_front();
      compare(sample(sel), e, tag, t);
      if (t == inject_at) begin
        iniciar = 1'b1; iniciar0 = 1'b1; ultimo = 4'd0;
      end
      if (t == inject_at + 1) begin
        iniciar = 1'b0; iniciar0 = 1'b0;
      end
`ifdef PAUSE_EN
      if (t == pause_at) begin
        pausa = 1'b1; pausa0 = 1'b1;
      end
      if (t == pause_at + pause_len) begin
        pausa = 1'b0; pausa0 = 1'b0;
      end
`endif
      if (t == clear_at) begin
        clear = 1'b1;
        @(negedge clock);
        compare(sample(sel), mk(4'h0, 1'b0, 1'b0, 0, 4'd0), {tag, "_clear"}, t + 1);
        clear = 1'b0;
        exp_q.delete();
      end
      t++;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 4'(i + 7);
    rom[0] = 4'b0001; rom[1] = 4'b0010; rom[2] = 4'b0100;
    clear = 1'b1; iniciar = 1'b0; iniciar0 = 1'b0; ultimo = 4'd0;
`ifdef PAUSE_EN
    pausa = 1'b0; pausa0 = 1'b0;
`endif
    repeat (2) @(posedge clock);
    @(negedge clock);
    compare(sample(1'b0), mk(4'h0, 1'b0, 1'b0, 0, 4'd0), "reset", 0);
    compare(sample(1'b1), mk(4'h0, 1'b0, 1'b0, 0, 4'd0), "reset0", 0);
    clear = 1'b0;

    run(1'b0, 1, 3, 2, 0, -1, -1, -1, "two_entries");
    run(1'b0, 0, 3, 2, 0, -1, -1, -1, "one_entry");
    run(1'b0, 1, 3, 2, 0, -1, -1, 11, "clear_mid_show");
    run(1'b0, 1, 3, 2, 0, -1, -1, -1, "restart");
    run(1'b0, 1, 3, 2, 0, -1, 5, -1, "ignore_start");
    run(1'b1, 2, 3, 0, 0, -1, -1, -1, "no_gap");
    run(1'b0, 15, 3, 2, 0, -1, -1, -1, "all_16");
`ifdef PAUSE_EN
    run(1'b0, 1, 3, 2, 4, 2, -1, -1, "pause");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
